// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-enable data memory: access sizes, controller
// states and the index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and lane-replicated write data,
// load lane extraction with sign/zero extension, and the alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wr_data_o,
    output logic [31:0] rd_data_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    size_e       size;

    assign size   = size_e'(size_i);
    assign half_v = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    always_comb begin
        byte_v = rd_word_i[7:0];
        case (addr_lo_i)
            2'd0: byte_v = rd_word_i[7:0];
            2'd1: byte_v = rd_word_i[15:8];
            2'd2: byte_v = rd_word_i[23:16];
            2'd3: byte_v = rd_word_i[31:24];
            default: byte_v = rd_word_i[7:0];
        endcase
    end

    always_comb begin
        be_o       = '0;
        wr_data_o  = wr_data_i;
        rd_data_o  = '0;
        misalign_o = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_o      = 4'b0001 << addr_lo_i;
                wr_data_o = {4{wr_data_i[7:0]}};
                rd_data_o = signed_i ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            end
            SZ_HALF: begin
                be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wr_data_o  = {2{wr_data_i[15:0]}};
                rd_data_o  = signed_i ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_o       = 4'b1111;
                rd_data_o  = rd_word_i;
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                misalign_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// MEM-stage data memory with byte-enable stores, extended loads, a registered
// req/rsp interface and a post-reset sequential clear sweep.
module data_mem_be
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic              rsp_valid,
    output logic [31:0]       rd_data,
    output logic              err,
    output logic              init_busy
);

    localparam int unsigned IDX_W = clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               init_busy_q, init_busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               err_q, err_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic [IDX_W-1:0]   idx;
    logic [31:0]        rd_word;
    logic [3:0]         be;
    logic [31:0]        st_data;
    logic [31:0]        ld_data;
    logic               misalign;
    logic               accept;
    logic               clear_we;
    logic               store_we;
    logic               unused_addr;

    // Upper address bits alias; only the word index and lane bits are decoded.
    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^addr;
    assign rd_word     = mem_q[idx];

    dmem_lane_align u_align (
        .size_i     (req_size),
        .signed_i   (req_signed),
        .addr_lo_i  (addr[1:0]),
        .wr_data_i  (wr_data),
        .rd_word_i  (rd_word),
        .be_o       (be),
        .wr_data_o  (st_data),
        .rd_data_o  (ld_data),
        .misalign_o (misalign)
    );

    assign accept   = req_valid && req_ready_q;
    assign store_we = accept && req_wr && !misalign;
    // The sweep is held off while reset is asserted so the array only changes on clean edges.
    assign clear_we = reset && (state_q == INIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = accept;
        err_d       = accept && misalign;
        rd_data_d   = rd_data_q;
        if (accept) begin
            rd_data_d = (!req_wr && !misalign) ? ld_data : '0;
        end
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = IDLE;
            end
        end
        req_ready_d = (state_d == IDLE);
        init_busy_d = (state_d == INIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (CLEAR_ON_RESET) begin
                state_q     <= INIT;
                init_busy_q <= 1'b1;
            end else begin
                state_q     <= IDLE;
                init_busy_q <= 1'b0;
            end
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            init_busy_q <= init_busy_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem_q[cnt_q] <= '0;
        end else if (store_we) begin
            if (be[0]) mem_q[idx][7:0]   <= st_data[7:0];
            if (be[1]) mem_q[idx][15:8]  <= st_data[15:8];
            if (be[2]) mem_q[idx][23:16] <= st_data[23:16];
            if (be[3]) mem_q[idx][31:24] <= st_data[31:24];
        end
    end

    assign req_ready = req_ready_q;
    assign init_busy = init_busy_q;
    assign rsp_valid = rsp_valid_q;
    assign err       = err_q;
    assign rd_data   = rd_data_q;

endmodule
